// File: rtl/result_serializer.sv
// result_serializer: captures LANES accumulator sums per tile into one of two
// banks and emits them one word per cycle to result_save, with per-word flags
// and a conv_done pulse at the end of the layer.

// One lane of the two-bank tile store.
module result_serializer_lane #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [ACC_W-1:0] din,
  input  logic             rd_bank,
  output logic [ACC_W-1:0] dout
);
  logic [1:0][ACC_W-1:0] mem;

  // Write the selected bank on capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      mem <= '0;
    else if (wr_en) mem[wr_bank] <= din;
  end

  assign dout = mem[rd_bank];
endmodule

module result_serializer #(
  parameter int LANES = 8,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [CNT_W-1:0]       img2col_t_num,
  input  logic [CNT_W-1:0]       kernel_num,
  input  logic                   acc_vld,
  input  logic [LANES*ACC_W-1:0] acc_data,
  output logic                   acc_rdy,
  output logic [ACC_W-1:0]       result,
  output logic [3:0]             result_valid,
  output logic                   conv_done,
  output logic                   ovf_err
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]             t_num_q, kn_q, t_idx, k_idx;
  logic [1:0]                   full;
  logic                         wr_sel, rd_sel, sbusy;
  logic [LW-1:0]                lane;
  logic [LANES-1:0][ACC_W-1:0]  acc_lanes, rd_word;
  logic                         start_ok, zero_cfg, cap, start_drain, word_en;
  logic                         last_word, t_last, k_last, layer_end;
  logic [ACC_W-1:0]             word;
  logic [3:0]                   rv_nxt;

  assign acc_lanes = acc_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    result_serializer_lane #(.ACC_W(ACC_W)) u_lane (
      .clk    (clk),
      .rstn   (rstn),
      .wr_en  (cap),
      .wr_bank(wr_sel),
      .din    (acc_lanes[i]),
      .rd_bank(rd_sel),
      .dout   (rd_word[i])
    );
  end

  assign start_ok  = (state == IDLE) && start;
  assign zero_cfg  = (img2col_t_num == '0) || (kernel_num == '0);
  assign acc_rdy   = (state == RUN) && !(full[0] && full[1]);
  assign cap       = acc_vld && acc_rdy;
  // An idle serializer starts on a full bank, or bypasses a tile being
  // captured into the read bank so lane 0 leaves one cycle after acc_vld.
  assign start_drain = !sbusy && (full[rd_sel] || (cap && (wr_sel == rd_sel)));
  assign word_en   = sbusy || start_drain;
  assign last_word = sbusy && (lane == LW'(LANES-1));
  assign t_last    = (t_idx == t_num_q - 1'b1);
  assign k_last    = (k_idx == kn_q - 1'b1);
  assign layer_end = last_word && t_last && k_last;
  assign word      = sbusy ? rd_word[lane] : (full[rd_sel] ? rd_word[0] : acc_lanes[0]);
  assign rv_nxt    = word_en ? {start_drain & t_last, start_drain, 2'b11} : 4'b0000;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_cfg ? DONE : RUN;
      RUN:     if (layer_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Config latch, bank occupancy, drain sequencing and tile/kernel counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t_num_q <= '0; kn_q <= '0; t_idx <= '0; k_idx <= '0;
      full <= '0; wr_sel <= 1'b0; rd_sel <= 1'b0; sbusy <= 1'b0; lane <= '0;
    end else if (start_ok) begin
      t_num_q <= img2col_t_num; kn_q <= kernel_num; t_idx <= '0; k_idx <= '0;
      full <= '0; wr_sel <= 1'b0; rd_sel <= 1'b0; sbusy <= 1'b0; lane <= '0;
    end else begin
      // Capture and release never touch the same bank in one cycle.
      if (cap) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
      if (start_drain) begin
        sbusy <= 1'b1;
        lane  <= LW'(1);
      end else if (sbusy) begin
        if (last_word) begin
          sbusy        <= 1'b0;
          lane         <= '0;
          full[rd_sel] <= 1'b0;
          rd_sel       <= ~rd_sel;
          if (t_last) begin
            t_idx <= '0;
            k_idx <= k_last ? '0 : k_idx + 1'b1;
          end else begin
            t_idx <= t_idx + 1'b1;
          end
        end else begin
          lane <= lane + 1'b1;
        end
      end
    end
  end

  // Registered outputs; result is zero when no word is emitted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      result <= '0; result_valid <= '0; conv_done <= 1'b0; ovf_err <= 1'b0;
    end else begin
      result       <= word_en ? word : '0;
      result_valid <= rv_nxt;
      conv_done    <= (state == DONE);
      ovf_err      <= ovf_err | (acc_vld & ~acc_rdy);
    end
  end
endmodule

// File: tb/tb_result_serializer.sv
module tb_result_serializer;
  localparam int LANES = 8;
  localparam int ACC_W = 32;
  localparam int CNT_W = 16;
  typedef logic [LANES*ACC_W-1:0] tile_t;

  logic                   clk = 1'b0;
  logic                   rstn;
  logic                   start;
  logic [CNT_W-1:0]       img2col_t_num, kernel_num;
  logic                   acc_vld;
  logic [LANES*ACC_W-1:0] acc_data;
  logic                   acc_rdy;
  logic [ACC_W-1:0]       result;
  logic [3:0]             result_valid;
  logic                   conv_done, ovf_err;

  result_serializer #(.LANES(LANES), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .img2col_t_num(img2col_t_num),
    .kernel_num(kernel_num), .acc_vld(acc_vld), .acc_data(acc_data),
    .acc_rdy(acc_rdy), .result(result), .result_valid(result_valid),
    .conv_done(conv_done), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a two-deep tile queue drained one word per cycle.
  int               mph;   // 0 idle, 1 running, 2 finishing
  int               tnum, kn, wpos, ord;
  tile_t            tq[$];
  logic             m_ovf, m_rdy, accepted;
  logic [ACC_W-1:0] e_res;
  logic [3:0]       e_rv;
  logic             e_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mph = 0; tq.delete(); wpos = 0; ord = 0; m_ovf = 0;
    e_res = '0; e_rv = '0; e_done = 0;
  endtask

  // Advance one clock: predict, clock, compare.
  task automatic step();
    tile_t t;
    m_rdy = (mph == 1) && (tq.size() < 2);
    chk("acc_rdy", acc_rdy, m_rdy);
    accepted = acc_vld && m_rdy;
    if (acc_vld && !m_rdy) m_ovf = 1;
    e_res = '0; e_rv = '0; e_done = 0;
    case (mph)
      0: if (start) begin
           tnum = img2col_t_num; kn = kernel_num; ord = 0; wpos = 0; tq.delete();
           mph = (tnum == 0 || kn == 0) ? 2 : 1;
         end
      1: begin
           if (accepted) tq.push_back(acc_data);
           if (tq.size() > 0) begin
             t = tq[0];
             e_res = t[wpos*ACC_W +: ACC_W];
             e_rv  = {(wpos == 0) && ((ord % tnum) == tnum - 1), wpos == 0, 2'b11};
             wpos++;
             if (wpos == LANES) begin
               void'(tq.pop_front());
               wpos = 0; ord++;
               if (ord == tnum * kn) mph = 2;
             end
           end
         end
      default: begin e_done = 1; mph = 0; end
    endcase
    @(posedge clk); #1;
    chk("result", result, e_res);
    chk("result_valid", result_valid, e_rv);
    chk("conv_done", conv_done, e_done);
    chk("ovf_err", ovf_err, m_ovf);
  endtask

  // Run one layer: start pulse, feed ntiles (forcing acc_vld for cycles
  // 1..hold regardless of readiness), then wait for the layer to close.
  // mode: 0 random, 1 ramp 1..LANES, 2 alternating signed extremes.
  task automatic feed(input int tn, input int kk, input int ntiles, input int hold, input int mode);
    int cnt = 0;
    int dn  = 0;
    logic pred;
    for (int i = 0; i < 200; i++) begin
      pred = (mph == 1) && (tq.size() < 2);
      start = (i == 0) || (i == 5);
      img2col_t_num = CNT_W'((i >= 5) ? tn + 1 : tn);
      kernel_num    = CNT_W'(kk);
      acc_vld = (cnt < ntiles) && ((i >= 1 && i <= hold) || pred);
      for (int l = 0; l < LANES; l++)
        acc_data[l*ACC_W +: ACC_W] = (mode == 0) ? ACC_W'($urandom) :
                                     (mode == 1) ? ACC_W'(l + 1) :
                                     ((l % 2) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      step();
      cnt += int'(accepted);
      dn  += int'(conv_done);
      if (i > 0 && mph == 0) break;
    end
    start = 0; acc_vld = 0;
    chk("tiles_accepted", cnt, ntiles);
    chk("done_pulses", dn, 1);
    chk("layer_closed", mph, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_done"}, conv_done, 0);
    chk({tag, "_ovf"}, ovf_err, 0);
    chk({tag, "_rdy"}, acc_rdy, 0);
  endtask

  initial begin
    rstn = 0; start = 0; acc_vld = 0; acc_data = '0;
    img2col_t_num = '0; kernel_num = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rstn = 1;

    // Single tile, ramp data: lane 0 at N+1, conv_done at N+9.
    feed(1, 1, 1, 0, 1);
    // Six tiles back to back, acc_vld offered whenever a bank is free.
    feed(3, 2, 6, 0, 0);
    chk("no_ovf_yet", ovf_err, 0);
    // acc_vld held through full banks: drops set ovf_err, later tile intact.
    feed(3, 1, 3, 6, 0);
    chk("ovf_sticky", ovf_err, 1);
    // Signed extremes pass unmodified.
    feed(1, 1, 1, 0, 2);
    // Zero configs close the layer with no words.
    feed(2, 0, 0, 0, 0);
    feed(0, 3, 0, 0, 0);

    // Reset in the middle of a drain.
    img2col_t_num = 2; kernel_num = 1; start = 1;
    step();
    start = 0; acc_vld = 1;
    for (int l = 0; l < LANES; l++) acc_data[l*ACC_W +: ACC_W] = ACC_W'($urandom);
    step();
    acc_vld = 0;
    repeat (4) step();
    rstn = 0;
    #1;
    chk_zero_outputs("midreset");
    model_reset();
    @(posedge clk); #1;
    rstn = 1;
    feed(1, 1, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
